// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing for the bit-serial subtractor: FSM encoding,
// default score width and counter sizing.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sub_state_e;

    localparam int SCORE_WIDTH = 20;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one full-subtractor cell plus a registered borrow.
// Optional macro SERIAL_SUB_SAT_FLOOR_EN floors diff at zero when the result borrows.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SCORE_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Holds the WIDTH-1 low result bits; the last bit comes straight from the cell.
    logic [WIDTH-2:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] res_full;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign res_full = {fs_d, res_q};

    // Next-state, datapath shift and output load logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    a_d     = A;
                    b_d     = B;
                    res_d   = {(WIDTH-1){1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    br_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                res_d = res_full[WIDTH-1:1];
                br_d  = fs_bout;
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    borrow_d = fs_bout;
`ifdef SERIAL_SUB_SAT_FLOOR_EN
                    if (fs_bout) begin
                        diff_d = {WIDTH{1'b0}};
                    end else begin
                        diff_d = res_full;
                    end
`else
                    diff_d = res_full;
`endif
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            res_q    <= {(WIDTH-1){1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            br_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=20.
// Expected values follow SERIAL_SUB_SAT_FLOOR_EN when it is defined.
module tb_serial_subtractor;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op, wait for done, check latency, result and the pulse width.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_diff, input logic exp_borrow);
        int n;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        check({tag, "_borrow"}, 32'(borrow), 32'(exp_borrow));
        tick();
        check({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        logic [W-1:0] floor_neg;
        int           n_done;
        logic [W-1:0] seen_diff;
`ifdef SERIAL_SUB_SAT_FLOOR_EN
        floor_neg = 20'h00000;
`else
        floor_neg = 20'hFFFFC;
`endif

        // 1: reset with a start pulse inside it
        A = 20'd5;
        B = 20'd9;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        tick();
        tick();
        check("rst_start_ignored", 32'(busy), 32'd0);

        // 2-4: directed ops
        run_op("t2", 20'd1000, 20'd250, 20'd750, 1'b0);
        run_op("t3", 20'd5, 20'd9, floor_neg, 1'b1);
        run_op("t4a", 20'hFFFFF, 20'hFFFFF, 20'h00000, 1'b0);
        run_op("t4b", 20'h00000, 20'h00000, 20'h00000, 1'b0);
`ifdef SERIAL_SUB_SAT_FLOOR_EN
        run_op("t4c", 20'h00000, 20'h00001, 20'h00000, 1'b1);
`else
        run_op("t4c", 20'h00000, 20'h00001, 20'hFFFFF, 1'b1);
`endif

        // 5: restart mid-operation and operand changes are ignored
        @(negedge clk);
        A = 20'd300;
        B = 20'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        A = 20'd7;
        B = 20'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 20'd12345;
        B = 20'd99;
        n_done = 0;
        seen_diff = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                n_done++;
                seen_diff = diff;
            end
        end
        check("t5_done_count", 32'(n_done), 32'd1);
        check("t5_diff", 32'(seen_diff), 32'd200);
        check("t5_borrow", 32'(borrow), 32'd0);

        // 6: reset mid-shift aborts
        @(negedge clk);
        A = 20'd1000;
        B = 20'd250;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        tick();
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_diff", 32'(diff), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) begin
                n_done++;
            end
        end
        check("t6_no_done", 32'(n_done), 32'd0);
        check("t6_idle_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
